// File: rtl/design_chan_pipe_top.sv
// Fans one input word into CHANNEL keyed lane pipelines of DEPTH mixing stages,
// reduces the lane results per run-time mode, and keeps a rolling signature and word count.
module design_chan_pipe_top #(
    parameter int WIDTH = 32,
    parameter int CHANNEL = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] SEED = WIDTH'(32'h0000_0001),
    parameter int SELW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [SELW-1:0]  chan_sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [WIDTH-1:0] sig,
    output logic [15:0]      count
);

    localparam logic [1:0] MODE_XOR  = 2'b00;
    localparam logic [1:0] MODE_ADD  = 2'b01;
    localparam logic [1:0] MODE_SEL  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int n);
        int amt;
        amt = n % WIDTH;
        if (amt == 0) begin
            return x;
        end
        return (x << amt) | (x >> (WIDTH - amt));
    endfunction

    logic [WIDTH-1:0] key   [CHANNEL];
    logic [WIDTH-1:0] stage [CHANNEL][DEPTH];
    logic [DEPTH-1:0] vpipe;
    logic [WIDTH-1:0] red_xor;
    logic [WIDTH-1:0] red_sum;
    logic [WIDTH-1:0] red_sel;
    logic [WIDTH-1:0] reduced;
    logic             hold;

    assign hold = (mode == MODE_HOLD);

    for (genvar c = 0; c < CHANNEL; c++) begin : g_key
        assign key[c] = rotl(SEED, c);
    end

    // Out-of-range lane selects match no lane and therefore reduce to zero.
    always_comb begin
        red_xor = '0;
        red_sum = '0;
        red_sel = '0;
        for (int c = 0; c < CHANNEL; c++) begin
            red_xor = red_xor ^ stage[c][DEPTH-1];
            red_sum = red_sum + stage[c][DEPTH-1];
            if (chan_sel == SELW'(c)) begin
                red_sel = stage[c][DEPTH-1];
            end
        end
        case (mode)
            MODE_XOR: reduced = red_xor;
            MODE_ADD: reduced = red_sum;
            MODE_SEL: reduced = red_sel;
            default:  reduced = red_sel;
        endcase
    end

    // HOLD freezes the whole pipeline in place; only out_valid is forced low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNEL; c++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    stage[c][k] <= '0;
                end
            end
            vpipe     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            sig       <= '0;
            count     <= '0;
        end else if (hold) begin
            out_valid <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNEL; c++) begin
                if (in_valid) begin
                    stage[c][0] <= in ^ key[c];
                end
                for (int k = 1; k < DEPTH; k++) begin
                    stage[c][k] <= {stage[c][k-1][WIDTH-2:0], stage[c][k-1][WIDTH-1]} + WIDTH'(k);
                end
            end
            vpipe[0] <= in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                vpipe[k] <= vpipe[k-1];
            end
            out_valid <= vpipe[DEPTH-1];
            if (vpipe[DEPTH-1]) begin
                out   <= reduced;
                sig   <= rotl(sig, 1) ^ reduced;
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_design_chan_pipe_top.sv
// Directed bench for design_chan_pipe_top: three configurations share one stimulus stream,
// checked against hand-computed vectors and a small lane model for the default configuration.
module tb_design_chan_pipe_top;

    logic        clk;
    logic        rst;
    logic [31:0] in_word;
    logic        in_valid;
    logic [1:0]  mode;
    logic [2:0]  sel_m;
    logic [0:0]  sel_s;

    logic [31:0] out_m, sig_m, out_a, sig_a, out_b, sig_b;
    logic        ov_m, ov_a, ov_b;
    logic [15:0] cnt_m, cnt_a, cnt_b;

    int checks = 0;
    int failures = 0;

    design_chan_pipe_top #(.WIDTH(32), .CHANNEL(8), .DEPTH(4), .SEED(32'h1)) u_main (
        .clk(clk), .rst(rst), .in(in_word), .in_valid(in_valid), .mode(mode),
        .chan_sel(sel_m), .out(out_m), .out_valid(ov_m), .sig(sig_m), .count(cnt_m)
    );

    design_chan_pipe_top #(.WIDTH(32), .CHANNEL(2), .DEPTH(1), .SEED(32'h1)) u_a (
        .clk(clk), .rst(rst), .in(in_word), .in_valid(in_valid), .mode(mode),
        .chan_sel(sel_s), .out(out_a), .out_valid(ov_a), .sig(sig_a), .count(cnt_a)
    );

    design_chan_pipe_top #(.WIDTH(32), .CHANNEL(1), .DEPTH(2), .SEED(32'h0)) u_b (
        .clk(clk), .rst(rst), .in(in_word), .in_valid(in_valid), .mode(mode),
        .chan_sel(sel_s), .out(out_b), .out_valid(ov_b), .sig(sig_b), .count(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] word;
        logic [1:0]  mode;
        logic        sel;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        if (n % 32 == 0) return x;
        return (x << (n % 32)) | (x >> (32 - (n % 32)));
    endfunction

    // Default configuration: 8 lanes, 4 stages, seed 1.
    function automatic logic [31:0] ref_main(input logic [31:0] w, input logic [1:0] m, input logic [2:0] s);
        logic [31:0] lane [8];
        logic [31:0] acc;
        for (int c = 0; c < 8; c++) begin
            lane[c] = w ^ rotl32(32'h1, c);
            for (int k = 1; k < 4; k++) begin
                lane[c] = rotl32(lane[c], 1) + 32'(k);
            end
        end
        acc = 32'h0;
        for (int c = 0; c < 8; c++) begin
            if (m == 2'b00) acc = acc ^ lane[c];
            else if (m == 2'b01) acc = acc + lane[c];
        end
        if (m == 2'b10) acc = lane[s];
        return acc;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] w, input logic v, input logic [1:0] m);
        in_word  = w;
        in_valid = v;
        mode     = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sm, sa, sb, exp_w;
    int cm, ca, cb;
    logic [31:0] expq[$];
    logic [31:0] w11;
    logic        in_hold;

    initial begin
        vecs[0] = '{32'habcdefab, 2'b00, 1'b0, 32'h00000003, 32'h579bdf58};
        vecs[1] = '{32'h00000000, 2'b01, 1'b0, 32'h00000003, 32'h00000001};
        vecs[2] = '{32'hffffffff, 2'b01, 1'b0, 32'hfffffffb, 32'h00000000};
        vecs[3] = '{32'h80000001, 2'b10, 1'b0, 32'h80000000, 32'h00000004};
        vecs[4] = '{32'h80000001, 2'b10, 1'b1, 32'h80000003, 32'h00000000};
        vecs[5] = '{32'h12345678, 2'b00, 1'b0, 32'h00000003, 32'h2468acf1};
        vecs[6] = '{32'h7fffffff, 2'b01, 1'b0, 32'hfffffffb, 32'hffffffff};
        vecs[7] = '{32'h00000003, 2'b10, 1'b1, 32'h00000001, 32'h00000000};
        vecs[8] = '{32'h00000003, 2'b10, 1'b0, 32'h00000002, 32'h00000007};

        // Reset held with a valid word on the input: everything must stay zero.
        rst   = 1'b1;
        sel_m = 3'd0;
        sel_s = 1'b0;
        applyStimulus(32'habcdefab, 1'b1, 2'b00);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("rst_out", out_m, 32'h0);
            checkOutput("rst_sig", sig_m, 32'h0);
            checkOutput("rst_vld_cnt", {15'h0, ov_m, cnt_m}, 32'h0);
        end
        rst = 1'b0;
        applyStimulus(32'h0, 1'b0, 2'b00);
        tick();

        // One word, XOR mode: latency is DEPTH+1 edges counting the sampling edge.
        applyStimulus(32'habcdefab, 1'b1, 2'b00);
        tick();
        applyStimulus(32'h0, 1'b0, 2'b00);
        checkOutput("lat_a_e1", 32'(ov_a), 32'h0);
        checkOutput("lat_m_e1", 32'(ov_m), 32'h0);
        for (int e = 2; e <= 6; e++) begin
            tick();
            checkOutput("lat_a_vld", 32'(ov_a), (e == 2) ? 32'h1 : 32'h0);
            checkOutput("lat_b_vld", 32'(ov_b), (e == 3) ? 32'h1 : 32'h0);
            checkOutput("lat_m_vld", 32'(ov_m), (e == 5) ? 32'h1 : 32'h0);
            if (e == 2) begin
                checkOutput("lat_a_out", out_a, 32'h3);
                checkOutput("lat_a_cnt", 32'(cnt_a), 32'h1);
            end
            if (e == 3) checkOutput("lat_b_out", out_b, 32'h579bdf58);
            if (e == 5) checkOutput("lat_m_out", out_m, ref_main(32'habcdefab, 2'b00, 3'd0));
        end
        sa = 32'h3;
        sb = 32'h579bdf58;
        sm = ref_main(32'habcdefab, 2'b00, 3'd0);
        ca = 1; cb = 1; cm = 1;

        // Table of single words under each reduction mode.
        for (int v = 0; v < 9; v++) begin
            sel_s = vecs[v].sel;
            sel_m = {2'b00, vecs[v].sel};
            applyStimulus(vecs[v].word, 1'b1, vecs[v].mode);
            tick();
            applyStimulus(32'h0, 1'b0, vecs[v].mode);
            repeat (5) tick();
            exp_w = ref_main(vecs[v].word, vecs[v].mode, {2'b00, vecs[v].sel});
            checkOutput($sformatf("vec%0d_a", v), out_a, vecs[v].exp_a);
            checkOutput($sformatf("vec%0d_b", v), out_b, vecs[v].exp_b);
            checkOutput($sformatf("vec%0d_m", v), out_m, exp_w);
            sa = rotl32(sa, 1) ^ vecs[v].exp_a;
            sb = rotl32(sb, 1) ^ vecs[v].exp_b;
            sm = rotl32(sm, 1) ^ exp_w;
            ca++; cb++; cm++;
        end
        checkOutput("tbl_sig_a", sig_a, sa);
        checkOutput("tbl_sig_b", sig_b, sb);
        checkOutput("tbl_sig_m", sig_m, sm);
        checkOutput("tbl_cnt_a", 32'(cnt_a), 32'(ca));
        checkOutput("tbl_cnt_b", 32'(cnt_b), 32'(cb));
        checkOutput("tbl_cnt_m", 32'(cnt_m), 32'(cm));

        // Continuous stream with five HOLD cycles in the middle.
        sel_m = 3'd0;
        sel_s = 1'b0;
        for (int t = 0; t < 40; t++) begin
            in_hold = (t >= 6 && t < 11);
            applyStimulus(32'h1111_0000 + 32'(t) * 32'h9e37_79b9, t < 16, in_hold ? 2'b11 : 2'b00);
            if (in_valid && !in_hold) expq.push_back(in_word);
            tick();
            if (in_hold) begin
                checkOutput("hold_vld", 32'(ov_m), 32'h0);
                checkOutput("hold_cnt", 32'(cnt_m), 32'(cm));
                checkOutput("hold_sig", sig_m, sm);
            end else if (ov_m) begin
                if (expq.size() == 0) begin
                    checkOutput("hold_extra", 32'(ov_m), 32'h0);
                end else begin
                    exp_w = ref_main(expq.pop_front(), 2'b00, 3'd0);
                    sm = rotl32(sm, 1) ^ exp_w;
                    cm++;
                    checkOutput("hold_out", out_m, exp_w);
                    checkOutput("hold_sig_run", sig_m, sm);
                end
            end
        end
        checkOutput("hold_drained", 32'(expq.size()), 32'h0);
        checkOutput("hold_cnt_end", 32'(cnt_m), 32'(cm));

        // Stream interrupted by an asynchronous reset pulse.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(32'h5a5a_0000 + 32'(i), 1'b1, 2'b00);
            tick();
        end
        applyStimulus(32'h5a5a_000a, 1'b1, 2'b00);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_out", out_m, 32'h0);
        checkOutput("arst_sig", sig_m, 32'h0);
        checkOutput("arst_vld_cnt", {15'h0, ov_m, cnt_m}, 32'h0);
        checkOutput("arst_a", {15'h0, ov_a, cnt_a}, 32'h0);
        checkOutput("arst_a_sig", sig_a, 32'h0);
        tick();
        rst = 1'b0;
        w11 = 32'h5a5a_000b;
        for (int j = 1; j <= 9; j++) begin
            applyStimulus(32'h5a5a_000a + 32'(j), 1'b1, 2'b00);
            tick();
            if (j == 1) checkOutput("post_a_e1", 32'(ov_a), 32'h0);
            if (j == 2) begin
                checkOutput("post_a_vld", 32'(ov_a), 32'h1);
                checkOutput("post_a_out", out_a, 32'h3);
                checkOutput("post_a_cnt", 32'(cnt_a), 32'h1);
                checkOutput("post_a_sig", sig_a, 32'h3);
            end
            if (j < 5) checkOutput("post_m_early", 32'(ov_m), 32'h0);
            if (j == 5) begin
                checkOutput("post_m_vld", 32'(ov_m), 32'h1);
                checkOutput("post_m_out", out_m, ref_main(w11, 2'b00, 3'd0));
                checkOutput("post_m_sig", sig_m, ref_main(w11, 2'b00, 3'd0));
                checkOutput("post_m_cnt", 32'(cnt_m), 32'h1);
            end
        end
        applyStimulus(32'h0, 1'b0, 2'b00);
        repeat (6) tick();
        checkOutput("post_m_cnt_end", 32'(cnt_m), 32'd9);
        checkOutput("post_a_cnt_end", 32'(cnt_a), 32'd9);
        checkOutput("post_b_cnt_end", 32'(cnt_b), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
